// File: rtl/sram_array_ctrl_256x22_if.sv
// Request/response bundle between a requester and the SRAM access controller.
// master: issues write/read requests, sees ready and read responses; slave: controller side.
interface sram_array_ctrl_256x22_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 22
);
    logic              w_req_valid;
    logic              w_req_ready;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_data;
    logic              r_req_valid;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;

    modport master (
        output w_req_valid, w_req_addr, w_req_data,
        output r_req_valid, r_req_addr,
        input  w_req_ready, r_req_ready,
        input  r_resp_valid, r_resp_data
    );

    modport slave (
        input  w_req_valid, w_req_addr, w_req_data,
        input  r_req_valid, r_req_addr,
        output w_req_ready, r_req_ready,
        output r_resp_valid, r_resp_data
    );
endinterface

// File: rtl/sram_array_ctrl_256x22.sv
// Access controller for a 256x22 single-port SRAM: zero-fills the array after
// reset, then merges write/read request channels onto the RW port (writes win).
// Ports: clock, reset (sync, active high); bus (slave modport: w_req_*, r_req_*,
// r_resp_*); init_done; sram_en/wmode/addr/wmask/wdata to macro; sram_rdata from it.
// Optional: SRAM_CTRL_HOLD_READ_EN keeps the last read data on r_resp_data.
module sram_array_ctrl_256x22 #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 22,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    sram_array_ctrl_256x22_if.slave  bus,
    output logic                     init_done,
    output logic                     sram_en,
    output logic                     sram_wmode,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic                     sram_wmask,
    output logic [DATA_W-1:0]        sram_wdata,
    input  logic [DATA_W-1:0]        sram_rdata
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_done;
    logic              r_resp_vld;

    logic w_run;
    logic w_init_wr;
    logic w_wr_fire;
    logic w_rd_fire;

    // Reset gates every macro access so nothing is written in the reset cycle.
    assign w_run     = !reset && (r_state == ST_RUN);
    assign w_init_wr = !reset && (r_state == ST_INIT);
    assign w_wr_fire = w_run && bus.w_req_valid;
    assign w_rd_fire = w_run && bus.r_req_valid && !bus.w_req_valid;

    assign bus.w_req_ready  = w_run;
    assign bus.r_req_ready  = w_run && !bus.w_req_valid;
    assign bus.r_resp_valid = r_resp_vld;
    assign init_done        = r_init_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_resp_vld  <= 1'b0;
        end else begin
            r_resp_vld <= w_rd_fire;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    // Finish on the last index, not on counter wrap.
                    if (r_init_cnt == LAST_IDX) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_wmask = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        unique case (1'b1)
            w_init_wr: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_wmask = 1'b1;
                sram_addr  = r_init_cnt;
                sram_wdata = INIT_VALUE;
            end
            w_wr_fire: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_wmask = 1'b1;
                sram_addr  = bus.w_req_addr;
                sram_wdata = bus.w_req_data;
            end
            w_rd_fire: begin
                sram_en   = 1'b1;
                sram_addr = bus.r_req_addr;
            end
            default: begin
            end
        endcase
    end

`ifdef SRAM_CTRL_HOLD_READ_EN
    logic [DATA_W-1:0] r_hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold <= '0;
        end else if (r_resp_vld) begin
            r_hold <= sram_rdata;
        end
    end

    assign bus.r_resp_data = r_resp_vld ? sram_rdata : r_hold;
`else
    assign bus.r_resp_data = sram_rdata;
`endif

endmodule
